// File: rtl/mult_ctrl_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier controller.
// Imported by mult_step_counter and mult_ctrl_param.
package mult_ctrl_pkg;

   localparam int MULT_DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } mult_state_e;

   // Counter must hold WIDTH-1; a 1-bit floor keeps degenerate widths legal.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Step counter for the multiplier controller: cleared at the start of an
// operation, advanced once per shift, saturating at WIDTH-1.
module mult_step_counter
   import mult_ctrl_pkg::*;
#(
   parameter int WIDTH = MULT_DEFAULT_WIDTH,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             clear,
   input  logic             increment,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(WIDTH - 1);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (increment && !last)
         cnt <= cnt + CNT_W'(1);
   end

   assign last = (cnt == TERM);

endmodule

// File: rtl/mult_ctrl_param.sv
// Sequencing controller for the shift-add multiplier datapath, generic in
// operand width. Optional feature macro: MULT_CTRL_SKIP_EN (shift in ADD when M=0).
module mult_ctrl_param
   import mult_ctrl_pkg::*;
#(
   parameter int WIDTH = MULT_DEFAULT_WIDTH,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Run,
   input  logic M,
   input  logic Signed_Mode,
   output logic Clear_XA,
   output logic Add,
   output logic Sub,
   output logic Shift_En,
   output logic Busy,
   output logic Done
);

   mult_state_e      state_q, state_d;
   logic             mode_q;
   logic             cnt_clr, cnt_inc, last;
   logic [CNT_W-1:0] cnt;
   logic             skip_shift;

   mult_step_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_cnt (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .clear     (cnt_clr),
      .increment (cnt_inc),
      .cnt       (cnt),
      .last      (last)
   );

`ifdef MULT_CTRL_SKIP_EN
   // A zero multiplier bit needs no add, so the shift is folded into ADD.
   assign skip_shift = (state_q == ADD) && !M;
`else
   assign skip_shift = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && Run)
            mode_q <= Signed_Mode;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Run) state_d = CLEAR;
         CLEAR:   state_d = ADD;
         ADD:     if (skip_shift) state_d = last ? HOLD : ADD;
                  else            state_d = SHIFT;
         SHIFT:   state_d = last ? HOLD : ADD;
         HOLD:    if (!Run) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign cnt_clr = (state_q == CLEAR);
   assign cnt_inc = ((state_q == SHIFT) || skip_shift) && !last;

   // Add/Sub follow M combinationally; everything else decodes state only.
   always_comb begin
      Clear_XA = 1'b0;
      Add      = 1'b0;
      Sub      = 1'b0;
      Shift_En = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      case (state_q)
         CLEAR: begin
            Clear_XA = 1'b1;
            Busy     = 1'b1;
         end
         ADD: begin
            Busy     = 1'b1;
            Add      = M;
            Sub      = M & mode_q & last;
            Shift_En = skip_shift;
         end
         SHIFT: begin
            Shift_En = 1'b1;
            Busy     = 1'b1;
         end
         HOLD:    Done = 1'b1;
         default: ;
      endcase
   end

   a_cnt_bound: assert property (@(posedge Clk) disable iff (!Reset_n)
      cnt <= CNT_W'(WIDTH - 1));
   a_excl: assert property (@(posedge Clk) disable iff (!Reset_n)
      $onehot0({Clear_XA, Add, Shift_En}) && (!Sub || Add));

endmodule

// File: tb/tb_mult_ctrl_param.sv
// Scoreboard bench for mult_ctrl_param: WIDTH=8 and WIDTH=5 instances, plus a
// small X:A:B datapath model on the WIDTH=8 instance to check products.
module tb_mult_ctrl_param;
   import mult_ctrl_pkg::*;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   logic Run8 = 0, Mode8 = 0, m8_const = 0, use_model = 0;
   logic Run5 = 0, Mode5 = 0, M5 = 0;
   logic M8;
   logic Clear8, Add8, Sub8, Shift8, Busy8, Done8;
   logic Clear5, Add5, Sub5, Shift5, Busy5, Done5;
   logic [5:0] out8, out5;

   mult_ctrl_param #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run8), .M(M8), .Signed_Mode(Mode8),
      .Clear_XA(Clear8), .Add(Add8), .Sub(Sub8), .Shift_En(Shift8),
      .Busy(Busy8), .Done(Done8));

   mult_ctrl_param #(.WIDTH(5)) dut5 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run5), .M(M5), .Signed_Mode(Mode5),
      .Clear_XA(Clear5), .Add(Add5), .Sub(Sub5), .Shift_En(Shift5),
      .Busy(Busy5), .Done(Done5));

   assign out8 = {Clear8, Add8, Sub8, Shift8, Busy8, Done8};
   assign out5 = {Clear5, Add5, Sub5, Shift5, Busy5, Done5};

   // Datapath model: X:A accumulate, X:A:B shift right, product = {A,B}
   logic [7:0] dp_A, dp_B, dp_S, dp_Bload;
   logic       dp_X, dp_signed;
   logic [8:0] ext_A, ext_S, dp_sum;

   assign M8 = use_model ? dp_B[0] : m8_const;

   always_comb begin
      ext_A  = dp_signed ? {dp_A[7], dp_A} : {1'b0, dp_A};
      ext_S  = dp_signed ? {dp_S[7], dp_S} : {1'b0, dp_S};
      dp_sum = Sub8 ? (ext_A - ext_S) : (ext_A + ext_S);
   end

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         dp_A <= '0; dp_B <= '0; dp_X <= 1'b0;
      end else if (Clear8) begin
         dp_A <= '0; dp_X <= 1'b0; dp_B <= dp_Bload;
      end else if (Add8) begin
         dp_A <= dp_sum[7:0]; dp_X <= dp_sum[8];
      end else if (Shift8) begin
         dp_A <= {dp_X, dp_A[7:1]};
         dp_B <= {dp_A[0], dp_B[7:1]};
         dp_X <= dp_signed & dp_X;
      end
   end

   typedef struct { int dut; int cyc; logic [5:0] exp; } sb_t;
   sb_t sbq[$];
   int  checks = 0;
   int  errors = 0;

   // Monitor: one expected output vector per pushed cycle
   always @(negedge Clk) begin
      if (sbq.size() > 0) begin
         sb_t e;
         logic [5:0] act;
         e   = sbq.pop_front();
         act = (e.dut == 0) ? out8 : out5;
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL ctrl dut%0d cycle %0d: got %b expected %b (Clr Add Sub Shf Busy Done)",
                     e.dut, e.cyc, act, e.exp);
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected schedule from the timing rules: cycle 1 CLEAR, then per bit an
   // ADD/SHIFT pair (or a lone shift for a skipped zero bit), then HOLD.
   task automatic build(input int w, input bit smode, input logic [63:0] bits,
                        input int run_len, output logic [5:0] s[$]);
      int h, hend;
      s = {};
      s.push_back(6'b100010);
      for (int i = 0; i < w; i++) begin
         logic b, sb;
         b  = bits[i];
         sb = b & smode & (i == w - 1);
`ifdef MULT_CTRL_SKIP_EN
         if (b) begin
            s.push_back({1'b0, 1'b1, sb, 1'b0, 1'b1, 1'b0});
            s.push_back(6'b000110);
         end else
            s.push_back(6'b000110);
`else
         s.push_back({1'b0, b, sb, 1'b0, 1'b1, 1'b0});
         s.push_back(6'b000110);
`endif
      end
      h    = s.size() + 1;
      hend = (run_len > h) ? run_len : h;
      for (int c = h; c <= hend; c++) s.push_back(6'b000001);
      for (int c = 0; c < 4; c++) s.push_back(6'b000000);
   endtask

   task automatic do_op(input int dut, input int w, input bit smode, input logic [63:0] bits,
                        input int run_len, input bit toggle, input int stop_at);
      logic [5:0] s[$];
      int n;
      build(w, smode, bits, run_len, s);
      n = (stop_at > 0) ? stop_at : s.size();
      @(posedge Clk); #1;
      if (dut == 0) begin Run8 = 1; Mode8 = smode; dp_signed = smode; end
      else          begin Run5 = 1; Mode5 = smode; end
      @(posedge Clk);
      for (int c = 1; c <= n; c++) begin
         logic mv;
         #1;
         mv = (toggle && c >= 3 && c <= 15) ? c[0] : smode;
         if (dut == 0) begin Run8 = (c < run_len); Mode8 = mv; end
         else          begin Run5 = (c < run_len); Mode5 = mv; end
         sbq.push_back('{dut, c, s[c-1]});
         @(posedge Clk);
      end
   endtask

   task automatic model_op(input bit smode, input logic [7:0] b, input logic [7:0] a,
                           input logic [15:0] exp, input string name);
      use_model = 1; dp_Bload = b; dp_S = a;
      do_op(0, 8, smode, {56'h0, b}, 1, 0, 0);
      check(name, {dp_A, dp_B}, exp);
      use_model = 0;
   endtask

   initial begin
      dp_signed = 0; dp_Bload = 0; dp_S = 0;
      #2;
      check("reset out8", {10'h0, out8}, 16'h0);
      check("reset out5", {10'h0, out5}, 16'h0);
      #10 Reset_n = 1;

      m8_const = 1;
      do_op(0, 8, 0, '1, 1, 0, 0);                 // unsigned, Run pulse, M=1
      do_op(0, 8, 1, '1, 1, 0, 0);                 // signed: Sub only in cycle 16
      model_op(1, 8'h03, 8'hFD, 16'hFFF7, "signed 03*FD");
      model_op(0, 8'hFF, 8'hFF, 16'hFE01, "unsigned FF*FF");

      M5 = 1;
      do_op(1, 5, 0, '1, 40, 0, 0);                // Run held: one op, Done 12..40

      // Reset mid-operation during cycle 7
      do_op(0, 8, 0, '1, 1, 0, 6);
      #2 Reset_n = 0;
      #1;
      check("async reset outputs", {10'h0, out8}, 16'h0);
      check("async reset state", {13'h0, dut8.state_q}, {13'h0, IDLE});
      #4 Reset_n = 1;
      model_op(0, 8'h0B, 8'h0D, 16'h008F, "after reset 0B*0D");

      model_op(0, 8'h00, 8'h5A, 16'h0000, "zero multiplier");
      m8_const = 1;
      do_op(0, 8, 0, '1, 1, 1, 0);                 // Signed_Mode toggles after unsigned start
      do_op(1, 5, 1, '1, 1, 0, 0);                 // WIDTH=5 signed: Sub in cycle 10

      repeat (3) @(posedge Clk);
      check("scoreboard drained", 16'(sbq.size()), 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mult_ctrl_param.md
# mult_ctrl_param

Parametrised sequencing controller for the shift-add multiplier datapath. It replaces the fixed 8-bit unrolled controller with a counter-driven state machine generic in operand width. It adds signed and unsigned modes, gating of the add step by the current multiplier bit, and Busy/Done status outputs. It sits between the top-level Run switch logic and the X/A/B register datapath, driving its Clear, Add, Sub and Shift controls.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..64; equals the number of add/shift steps
- CNT_W, $clog2(WIDTH), step counter width; derived, not overridden
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Run  in  1  start request, level; already debounced and synchronised
- M  in  1  current multiplier LSB (B[0]) from the datapath
- Signed_Mode  in  1  1 selects two's-complement operation; 0 selects unsigned
- Clear_XA  out  1  clear X and A registers; load operands
- Add  out  1  add the multiplicand into A this cycle
- Sub  out  1  with Add, subtract instead of add
- Shift_En  out  1  arithmetic-shift X:A:B right by one
- Busy  out  1  an operation is in progress
- Done  out  1  result valid in the datapath

## Operation
- States: IDLE, CLEAR, ADD, SHIFT, HOLD; state encoding and counter reset asynchronously to IDLE and 0 when Reset_n=0.
- Reset value of every output is 0.
- IDLE: all outputs 0. On Run=1, latch Signed_Mode into mode_q and go to CLEAR.
- CLEAR: Clear_XA=1, Busy=1, cnt←0, next ADD.
- ADD: Busy=1, Add=M, Sub=M & mode_q & (cnt==WIDTH-1), next SHIFT.
- SHIFT: Shift_En=1, Busy=1. If cnt==WIDTH-1 go to HOLD, else cnt←cnt+1 and go to ADD.
- HOLD: Done=1, all other outputs 0. Stay while Run=1; on Run=0 go to IDLE.
- Unsigned mode never asserts Sub. The datapath handles the sign-extension difference via the X bit.
- Signed_Mode changes after the start edge are ignored until the next IDLE→CLEAR transition.
- Add, Shift_En and Clear_XA are mutually exclusive in every cycle.
- Sub is never high without Add.
- cnt never wraps. Its terminal value is WIDTH-1, including non-power-of-two WIDTH.

## Timing
- Moore outputs, except Add and Sub, which are combinational from M in ADD.
- M must be stable from the datapath clock-to-q; no other same-cycle dependency exists.
- Run sampled high at edge 0:
  - CLEAR occupies cycle 1.
  - ADD/SHIFT pairs occupy cycles 2..2·WIDTH+1.
  - Done rises in cycle 2·WIDTH+2, i.e. cycle 18 for WIDTH=8.
- Run held high through HOLD does not restart the operation; a new start needs Run low for at least one cycle.
- Run dropping mid-operation has no effect; the operation completes and HOLD exits on the next cycle.
- Reset_n asserted mid-operation forces IDLE immediately and all outputs to 0. There is no partial result guarantee.

## Configuration
- MULT_CTRL_SKIP_EN defined: in ADD with M=0 the controller performs the shift in that same cycle and does not visit SHIFT.
  - In that cycle Shift_En=1, Add=0, and the cnt and terminal rules of SHIFT apply.
  - Latency becomes 1 + WIDTH + popcount(B) cycles from the start edge to the last step.
- MULT_CTRL_SKIP_EN undefined: fixed latency as above; ADD with M=0 is an idle add cycle with all step outputs 0.

## Structure
- Package mult_ctrl_pkg holds:
  - the state enum typedef mult_state_e;
  - the function computing CNT_W;
  - the localparam default width.
- Sub-module mult_step_counter holds the step counter.
  - Inputs: clear, increment.
  - Outputs: cnt, last.
  - Async active-low reset to 0.
  - last = (cnt==WIDTH-1).

## Test plan
- WIDTH=8, unsigned, Run pulse, M held 1 → Clear_XA in cycle 1; Add in even cycles 2..16, Sub never; Shift_En in odd cycles 3..17; Done from cycle 18.
- WIDTH=8, signed, M=1 throughout → Sub=1 only in cycle 16, coincident with Add; B=0x03 × A=0xFD yields 0xFFF7 in the datapath model.
- WIDTH=5, Run held high for 40 cycles → exactly one operation; Done from cycle 12 stays high; IDLE is re-entered one cycle after Run falls.
- Reset_n pulsed low during cycle 7 → outputs 0 asynchronously, state IDLE; a new Run completes normally.
- MULT_CTRL_SKIP_EN, WIDTH=8, B=0x00 → no Add; 8 consecutive Shift_En cycles 2..9; Done from cycle 10.
- Signed_Mode toggled during cycles 3..15 after an unsigned start → Sub never asserted.
